// File: rtl/inst_cache.sv
// inst_cache: direct-mapped read-only instruction cache across IF1/IF2.
// Define ICACHE_PERF_EN to add the perf_hit_cnt/perf_miss_cnt counters.
module inst_cache #(
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 2,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_if1,
    input  logic              stall_if1_if2,
    input  logic              flush_if1_if2,
    output logic [31:0]       inst_if2,
    output logic              inst_sram_miss,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
`ifdef ICACHE_PERF_EN
    output logic [31:0]       perf_hit_cnt,
    output logic [31:0]       perf_miss_cnt,
`endif
    input  logic [31:0]       mem_rdata
);

    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W - 2;
    localparam int LINES    = 1 << INDEX_W;
    localparam int WORDS    = 1 << OFFSET_W;
    localparam int LINE_LSB = OFFSET_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        DONE
    } state_t;

    logic [ADDR_W-1:0]   req_addr_q;
    logic                req_valid_q;
    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [31:0]         data_q [LINES][WORDS];

    state_t              state_q, state_d;
    logic [OFFSET_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0]   miss_addr_q, miss_addr_d;

    logic                data_we;
    logic                fill_done;
    logic                hit;

    logic [INDEX_W-1:0]  req_idx;
    logic [OFFSET_W-1:0] req_off;
    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  miss_idx;
    logic [TAG_W-1:0]    miss_tag;
    logic                unused_ok;

    assign req_idx   = req_addr_q[LINE_LSB +: INDEX_W];
    assign req_off   = req_addr_q[2 +: OFFSET_W];
    assign req_tag   = req_addr_q[ADDR_W-1 -: TAG_W];
    assign miss_idx  = miss_addr_q[LINE_LSB +: INDEX_W];
    assign miss_tag  = miss_addr_q[ADDR_W-1 -: TAG_W];
    assign unused_ok = ^req_addr_q[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr_q  <= '0;
            req_valid_q <= 1'b0;
        end else if (flush_if1_if2) begin
            req_valid_q <= 1'b0;
        end else if (!stall_if1_if2) begin
            req_addr_q  <= pc_if1;
            req_valid_q <= 1'b1;
        end
    end

    assign hit = req_valid_q && valid_q[req_idx] &&
                 (tag_q[req_idx] == req_tag) && (state_q == IDLE);

    assign inst_if2       = hit ? data_q[req_idx][req_off] : 32'h0;
    assign inst_sram_miss = (state_q != IDLE) || (req_valid_q && !hit);
    assign mem_addr       = miss_addr_q;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        miss_addr_d = miss_addr_q;
        mem_req     = 1'b0;
        data_we     = 1'b0;
        fill_done   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid_q && !hit) begin
                    miss_addr_d = {req_addr_q[ADDR_W-1:LINE_LSB],
                                   {LINE_LSB{1'b0}}};
                    state_d     = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    state_d = FILL;
                    beat_d  = '0;
                end
            end
            FILL: begin
                if (mem_rvalid) begin
                    data_we = 1'b1;
                    beat_d  = beat_q + 1'b1;
                    if (beat_q == '1) begin
                        fill_done = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            miss_addr_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            miss_addr_q <= miss_addr_d;
            if (fill_done) begin
                valid_q[miss_idx] <= 1'b1;
            end
        end
    end

    // Tag/data storage carries no reset; valid_q alone qualifies it.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[miss_idx][beat_q] <= mem_rdata;
        end
        if (fill_done) begin
            tag_q[miss_idx] <= miss_tag;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit && !stall_if1_if2) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if ((state_q == IDLE) && (state_d == REQ)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign perf_hit_cnt  = hit_cnt_q;
    assign perf_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: directed vector table plus hand sequences for inst_cache.
// Covers cold miss, hits, eviction, flush, gapped beats, reset mid-refill.
module tb_inst_cache;

    logic        clk;
    logic        rst;
    logic [31:0] pc_if1;
    logic        stall_if1_if2;
    logic        flush_if1_if2;
    logic [31:0] inst_if2;
    logic        inst_sram_miss;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hit_cnt;
    logic [31:0] perf_miss_cnt;
`endif

    int errors = 0;
    int checks = 0;

    inst_cache dut (
        .clk            (clk),
        .rst            (rst),
        .pc_if1         (pc_if1),
        .stall_if1_if2  (stall_if1_if2),
        .flush_if1_if2  (flush_if1_if2),
        .inst_if2       (inst_if2),
        .inst_sram_miss (inst_sram_miss),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
`ifdef ICACHE_PERF_EN
        .perf_hit_cnt   (perf_hit_cnt),
        .perf_miss_cnt  (perf_miss_cnt),
`endif
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        st;
        logic        fl;
        logic        gn;
        logic        rv;
        logic [31:0] rd;
        logic        e_miss;
        logic [31:0] e_inst;
        logic        e_req;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [31:0] pc, input logic st, input logic fl,
                       input logic gn, input logic rv, input logic [31:0] rd,
                       input logic em, input logic [31:0] ei,
                       input logic er, input logic [31:0] ea);
        vec_t v;
        v.pc = pc; v.st = st; v.fl = fl; v.gn = gn; v.rv = rv; v.rd = rd;
        v.e_miss = em; v.e_inst = ei; v.e_req = er; v.e_addr = ea;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic em,
                           input logic [31:0] ei, input logic er,
                           input logic [31:0] ea);
        chk({nm, ".miss"}, {31'b0, inst_sram_miss}, {31'b0, em});
        chk({nm, ".inst"}, inst_if2, ei);
        chk({nm, ".req"}, {31'b0, mem_req}, {31'b0, er});
        if (er) chk({nm, ".addr"}, mem_addr, ea);
    endtask

    // Drive inputs just after an edge, clock once, compare registered outputs.
    task automatic cyc(input string nm, input logic [31:0] pc,
                       input logic st, input logic fl, input logic gn,
                       input logic rv, input logic [31:0] rd,
                       input logic em, input logic [31:0] ei,
                       input logic er, input logic [31:0] ea);
        pc_if1 = pc; stall_if1_if2 = st; flush_if1_if2 = fl;
        mem_gnt = gn; mem_rvalid = rv; mem_rdata = rd;
        @(posedge clk);
        #1;
        chk_out(nm, em, ei, er, ea);
    endtask

    initial begin
        rst = 1'b1;
        pc_if1 = '0; stall_if1_if2 = 1'b0; flush_if1_if2 = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // cold miss of 0x100, grant two cycles after request
        add(32'h100, 0, 0, 0, 0, 32'h0,  1, 32'h0,  0, 32'h0);
        add(32'h100, 1, 0, 0, 0, 32'h0,  1, 32'h0,  1, 32'h100);
        add(32'h100, 1, 0, 0, 0, 32'h0,  1, 32'h0,  1, 32'h100);
        add(32'h100, 1, 0, 1, 0, 32'h0,  1, 32'h0,  0, 32'h0);
        add(32'h100, 1, 0, 0, 1, 32'hA0, 1, 32'h0,  0, 32'h0);
        add(32'h100, 1, 0, 0, 1, 32'hA1, 1, 32'h0,  0, 32'h0);
        add(32'h100, 1, 0, 0, 1, 32'hA2, 1, 32'h0,  0, 32'h0);
        add(32'h100, 1, 0, 0, 1, 32'hA3, 1, 32'h0,  0, 32'h0);
        add(32'h100, 1, 0, 0, 0, 32'h0,  0, 32'hA0, 0, 32'h0);
        // hit streak
        add(32'h104, 0, 0, 0, 0, 32'h0,  0, 32'hA1, 0, 32'h0);
        add(32'h108, 0, 0, 0, 0, 32'h0,  0, 32'hA2, 0, 32'h0);
        add(32'h10C, 0, 0, 0, 0, 32'h0,  0, 32'hA3, 0, 32'h0);
        // conflict eviction by 0x500
        add(32'h500, 0, 0, 0, 0, 32'h0,  1, 32'h0,  0, 32'h0);
        add(32'h500, 1, 0, 0, 0, 32'h0,  1, 32'h0,  1, 32'h500);
        add(32'h500, 1, 0, 1, 0, 32'h0,  1, 32'h0,  0, 32'h0);
        add(32'h500, 1, 0, 0, 1, 32'hB0, 1, 32'h0,  0, 32'h0);
        add(32'h500, 1, 0, 0, 1, 32'hB1, 1, 32'h0,  0, 32'h0);
        add(32'h500, 1, 0, 0, 1, 32'hB2, 1, 32'h0,  0, 32'h0);
        add(32'h500, 1, 0, 0, 1, 32'hB3, 1, 32'h0,  0, 32'h0);
        add(32'h500, 1, 0, 0, 0, 32'h0,  0, 32'hB0, 0, 32'h0);
        add(32'h100, 0, 0, 0, 0, 32'h0,  1, 32'h0,  0, 32'h0);
        add(32'h100, 1, 0, 0, 0, 32'h0,  1, 32'h0,  1, 32'h100);
        add(32'h100, 1, 0, 1, 0, 32'h0,  1, 32'h0,  0, 32'h0);
        add(32'h100, 1, 0, 0, 1, 32'hC0, 1, 32'h0,  0, 32'h0);
        add(32'h100, 1, 0, 0, 1, 32'hC1, 1, 32'h0,  0, 32'h0);
        add(32'h100, 1, 0, 0, 1, 32'hC2, 1, 32'h0,  0, 32'h0);
        add(32'h100, 1, 0, 0, 1, 32'hC3, 1, 32'h0,  0, 32'h0);
        // stray rvalid outside FILL is ignored
        add(32'h100, 1, 0, 0, 1, 32'hDEAD, 0, 32'hC0, 0, 32'h0);
        add(32'h10C, 0, 0, 0, 1, 32'hDEAD, 0, 32'hC3, 0, 32'h0);
        // stall+flush together: flush wins, then stall holds invalid
        add(32'h10C, 1, 1, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0);
        add(32'h10C, 1, 0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0);
        add(32'h108, 0, 0, 0, 0, 32'h0,  0, 32'hC2, 0, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc($sformatf("vec%0d", i), tbl[i].pc, tbl[i].st, tbl[i].fl,
                tbl[i].gn, tbl[i].rv, tbl[i].rd, tbl[i].e_miss,
                tbl[i].e_inst, tbl[i].e_req, tbl[i].e_addr);
        end

        // flush during FILL: burst completes, no second request
        cyc("fl.miss", 32'h200, 0, 0, 0, 0, 32'h0,  1, 32'h0, 0, 32'h0);
        cyc("fl.req",  32'h200, 1, 0, 0, 0, 32'h0,  1, 32'h0, 1, 32'h200);
        cyc("fl.gnt",  32'h200, 1, 0, 1, 0, 32'h0,  1, 32'h0, 0, 32'h0);
        cyc("fl.b0",   32'h200, 1, 0, 0, 1, 32'hD0, 1, 32'h0, 0, 32'h0);
        cyc("fl.b1",   32'h200, 1, 1, 0, 1, 32'hD1, 1, 32'h0, 0, 32'h0);
        cyc("fl.b2",   32'h200, 1, 0, 0, 1, 32'hD2, 1, 32'h0, 0, 32'h0);
        cyc("fl.b3",   32'h200, 1, 0, 0, 1, 32'hD3, 1, 32'h0, 0, 32'h0);
        cyc("fl.idle", 32'h200, 1, 0, 0, 0, 32'h0,  0, 32'h0, 0, 32'h0);
        cyc("fl.hold", 32'h200, 1, 0, 0, 0, 32'h0,  0, 32'h0, 0, 32'h0);
        cyc("fl.hold", 32'h200, 1, 0, 0, 0, 32'h0,  0, 32'h0, 0, 32'h0);
        cyc("fl.hit",  32'h204, 0, 0, 0, 0, 32'h0,  0, 32'hD1, 0, 32'h0);

        // gapped beats 1,0,0,1,1,0,1
        cyc("gp.miss", 32'h300, 0, 0, 0, 0, 32'h0,   1, 32'h0, 0, 32'h0);
        cyc("gp.req",  32'h300, 1, 0, 0, 0, 32'h0,   1, 32'h0, 1, 32'h300);
        cyc("gp.gnt",  32'h300, 1, 0, 1, 0, 32'h0,   1, 32'h0, 0, 32'h0);
        cyc("gp.r0",   32'h300, 1, 0, 0, 1, 32'hE0,  1, 32'h0, 0, 32'h0);
        cyc("gp.r1",   32'h300, 1, 0, 0, 0, 32'hBAD, 1, 32'h0, 0, 32'h0);
        cyc("gp.r2",   32'h300, 1, 0, 0, 0, 32'hBAD, 1, 32'h0, 0, 32'h0);
        cyc("gp.r3",   32'h300, 1, 0, 0, 1, 32'hE1,  1, 32'h0, 0, 32'h0);
        cyc("gp.r4",   32'h300, 1, 0, 0, 1, 32'hE2,  1, 32'h0, 0, 32'h0);
        cyc("gp.r5",   32'h300, 1, 0, 0, 0, 32'hBAD, 1, 32'h0, 0, 32'h0);
        cyc("gp.r6",   32'h300, 1, 0, 0, 1, 32'hE3,  1, 32'h0, 0, 32'h0);
        cyc("gp.w0",   32'h300, 1, 0, 0, 0, 32'h0,   0, 32'hE0, 0, 32'h0);
        cyc("gp.w1",   32'h304, 0, 0, 0, 0, 32'h0,   0, 32'hE1, 0, 32'h0);
        cyc("gp.w2",   32'h308, 0, 0, 0, 0, 32'h0,   0, 32'hE2, 0, 32'h0);
        cyc("gp.w3",   32'h30C, 0, 0, 0, 0, 32'h0,   0, 32'hE3, 0, 32'h0);

        // reset mid-FILL after two beats
        cyc("rs.miss", 32'h400, 0, 0, 0, 0, 32'h0,  1, 32'h0, 0, 32'h0);
        cyc("rs.req",  32'h400, 1, 0, 0, 0, 32'h0,  1, 32'h0, 1, 32'h400);
        cyc("rs.gnt",  32'h400, 1, 0, 1, 0, 32'h0,  1, 32'h0, 0, 32'h0);
        cyc("rs.b0",   32'h400, 1, 0, 0, 1, 32'hF0, 1, 32'h0, 0, 32'h0);
        cyc("rs.b1",   32'h400, 1, 0, 0, 1, 32'hF1, 1, 32'h0, 0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk_out("rs.async", 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_rvalid = 1'b0;
        // 0x100 was resident before reset; it must miss now
        cyc("rs.m100", 32'h100, 0, 0, 0, 0, 32'h0, 1, 32'h0, 0, 32'h0);
        cyc("rs.r100", 32'h100, 1, 0, 0, 0, 32'h0, 1, 32'h0, 1, 32'h100);
        // reset while requesting drops mem_req at once
        #2;
        rst = 1'b1;
        #1;
        chk_out("rs.reqdrop", 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("rs.m400", 32'h400, 0, 0, 0, 0, 32'h0, 1, 32'h0, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Direct-mapped, read-only instruction cache spanning the IF1/IF2 fetch stages.
- IF1 presents the PC. IF2 returns the instruction on a hit, or raises inst_sram_miss, which the pipeline hazard unit uses to stall IF1/IF2 and bubble IF/ID.
- Acts as the responder for that miss signal and as the initiator of line refills to the memory port.
- Honours the hazard unit's stall_if1_if2 and flush_if1_if2 controls.

Parameters:
- INDEX_W, 6, line index bits (64 lines).
- OFFSET_W, 2, word-offset bits (4 words of 32 bits per line).
- ADDR_W, 32, address width. Tag width = ADDR_W-INDEX_W-OFFSET_W-2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- pc_if1  in  ADDR_W  fetch address issued in IF1; word aligned.
- stall_if1_if2  in  1  hold the IF2 request register.
- flush_if1_if2  in  1  invalidate the IF2 request register.
- inst_if2  out  32  instruction for the IF2 request.
- inst_sram_miss  out  1  IF2 result not available this cycle.
- mem_req  out  1  refill request, held until granted.
- mem_addr  out  ADDR_W  line-aligned refill address.
- mem_gnt  in  1  memory accepted the request.
- mem_rvalid  in  1  one refill data beat valid.
- mem_rdata  in  32  refill data beat, in word order 0..2^OFFSET_W-1.

Behaviour:
- IF2 request register {req_addr, req_valid}:
  - Reset: req_valid=0, req_addr=0.
  - Each clock edge, flush_if1_if2 has priority: it sets req_valid=0.
  - Otherwise, if !stall_if1_if2: req_addr<=pc_if1, req_valid<=1.
  - Otherwise: hold.
- Arrays:
  - valid[2^INDEX_W] is cleared by reset.
  - Tag and data arrays are not reset.
  - Read is combinational on req_addr.
- hit = req_valid & valid[idx] & tag match & state==IDLE.
- Outputs:
  - inst_if2 = data word selected by the offset when hit, else 0.
  - inst_sram_miss = (state!=IDLE) | (req_valid & !hit).
  - Hit latency: 1 cycle, i.e. pc_if1 at edge N gives inst_if2 valid during cycle N+1.
- FSM states: IDLE, REQ, FILL, DONE. Reset state is IDLE, with mem_req=0 and beat counter=0.
  - IDLE: on req_valid & !hit, latch line address into miss_addr and go to REQ.
  - REQ: mem_req=1, mem_addr=miss_addr with offset bits zeroed. On mem_gnt go to FILL with beat counter=0.
  - FILL: each mem_rvalid writes mem_rdata to data[idx][beat] and increments beat. On the last beat, write the tag, set valid[idx]=1, and go to DONE. Cycles without mem_rvalid wait with no timeout.
  - DONE: one cycle with inst_sram_miss=1, then IDLE. The re-lookup then hits.
- A refill always completes once granted; there is no abort. Flush during REQ/FILL/DONE clears req_valid only. The filled line stays valid, and inst_sram_miss remains high until IDLE.
- A new request arriving during a refill is served only after IDLE. If it targets the line being filled, it hits after DONE.
- mem_rvalid outside FILL is ignored.
- The counter is OFFSET_W bits wide. The last beat is the one with beat == all ones; the counter wraps to 0.
- Stall and flush both asserted on the same edge: flush wins.
- Reset mid-refill:
  - Returns to IDLE, invalidates all lines, drops mem_req immediately.
  - The memory side must discard the outstanding burst.

Optional Feature:
- Macro ICACHE_PERF_EN.
- Defined:
  - Adds output ports perf_hit_cnt[31:0] and perf_miss_cnt[31:0], both reset to 0.
  - hit_cnt increments on each cycle with hit & !stall_if1_if2.
  - miss_cnt increments on each IDLE→REQ transition.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Cold miss:
  - Stimulus: after reset, pc_if1=0x100, no stall; mem_gnt 2 cycles after mem_req; 4 back-to-back rvalid beats 0xA0..0xA3.
  - Required: mem_addr=0x100 and inst_sram_miss high until DONE+1; then inst_if2=0xA0 with miss=0.
- Hit streak: after the fill above, pc_if1=0x104, 0x108, 0x10C on consecutive cycles → inst_if2=0xA1, 0xA2, 0xA3, each 1 cycle later, with no mem_req.
- Conflict eviction:
  - Stimulus: fill 0x100, then fetch 0x100+(1<<(INDEX_W+OFFSET_W+2)).
  - Required: miss and refill. A later fetch of 0x100 misses again.
- Flush during FILL: assert flush_if1_if2 mid-burst → burst completes, valid set, req_valid=0, miss drops at IDLE, and no second mem_req is issued.
- Gapped beats: rvalid pattern 1,0,0,1,1,0,1 → exactly 4 writes in order; DONE only after the 4th beat.
- Reset mid-FILL: assert rst after 2 beats → mem_req=0 and inst_sram_miss=0 immediately; the next fetch of the same line misses (valid cleared).
